// File: rtl/mcart_rst_sel_pkg.sv
// Shared types and constants for the multicart reset-button game selector.
// Optional selection lock is compiled in with MCART_LOCK_EN.
package mcart_rst_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HELD  = 2'd2
    } deb_state_e;

    localparam logic [7:0]  SS_ADDR_SEL = 8'd0;
    localparam logic [7:0]  SS_ADDR_IDX = 8'd127;

    // CPU write window that arms the selection lock: 0x5000-0x5FFF
    localparam logic [15:0] LOCK_BASE   = 16'h5000;
    localparam logic [15:0] LOCK_MASK   = 16'hF000;

endpackage

// File: rtl/mcart_rst_sel_if.sv
// CPU and save-state bus bundle for mcart_rst_sel.
// Handshake: no valid/ready; every field is a level sampled on the m2 falling edge, ss_rdat is combinational.
interface mcart_rst_sel_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dat;
    logic        cpu_rw;
    logic        ss_act;
    logic        ss_we;
    logic [7:0]  ss_addr;
    logic [7:0]  ss_wdat;
    logic [7:0]  map_idx;
    logic [7:0]  ss_rdat;

    modport master (
        output cpu_addr, cpu_dat, cpu_rw,
        output ss_act, ss_we, ss_addr, ss_wdat, map_idx,
        input  ss_rdat
    );

    modport slave (
        input  cpu_addr, cpu_dat, cpu_rw,
        input  ss_act, ss_we, ss_addr, ss_wdat, map_idx,
        output ss_rdat
    );
endinterface

// File: rtl/mcart_btn_deb.sv
// Reset-button synchroniser and debounce FSM: one pulse_out per press held DEB_CYC cycles.
// pulse_out is gated by arm_en, but the FSM keeps tracking the button regardless.
module mcart_btn_deb
    import mcart_rst_sel_pkg::*;
#(
    parameter int DEB_CYC = 16
) (
    input  logic m2,
    input  logic map_rst_n,
    input  logic btn_in,
    input  logic arm_en,
    output logic pulse_out
);

    localparam logic [7:0] DEB_LIM = 8'(DEB_CYC);

    logic       sync1_q;
    logic       rst_s;
    deb_state_e state_q;
    logic [7:0] cnt_q;
    logic       pulse_q;

    always_ff @(negedge m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            sync1_q <= 1'b0;
            rst_s   <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            rst_s   <= sync1_q;
        end
    end

    // cnt_q holds the number of consecutive high samples seen so far
    always_ff @(negedge m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rst_s) begin
                        cnt_q <= 8'd1;
                        if (DEB_LIM == 8'd1) begin
                            state_q <= HELD;
                            pulse_q <= 1'b1;
                        end else begin
                            state_q <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (!rst_s) begin
                        state_q <= IDLE;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == DEB_LIM) begin
                            state_q <= HELD;
                            pulse_q <= 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!rst_s) begin
                        state_q <= IDLE;
                        cnt_q   <= 8'd0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    assign pulse_out = pulse_q & arm_en;

endmodule

// File: rtl/mcart_rst_sel.sv
// Multicart game selector: console reset presses step game_sel, save-state bus loads/reads it.
// Define MCART_LOCK_EN to add a CPU-settable lock that freezes button advances.
module mcart_rst_sel
    import mcart_rst_sel_pkg::*;
#(
    parameter int GAME_CNT = 4,
    parameter int SEL_W    = 2,
    parameter int DEB_CYC  = 16
) (
    input  logic             m2,
    input  logic             map_rst_n,
    input  logic             sys_rst,
    mcart_rst_sel_if.slave   bus,
    output logic [SEL_W-1:0] game_sel,
    output logic             sel_lock
);

    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(GAME_CNT - 1);

    logic             advance;
    logic             arm_en;
    logic             ss_wr;
    logic [SEL_W-1:0] ss_val;
    logic [SEL_W-1:0] game_sel_q;
    logic [7:0]       rdat;
    logic             unused_wdat;

    assign arm_en      = ~bus.ss_act & ~sel_lock;
    assign ss_wr       = bus.ss_act & bus.ss_we & (bus.ss_addr == SS_ADDR_SEL);
    assign ss_val      = bus.ss_wdat[SEL_W-1:0];
    assign unused_wdat = ^bus.ss_wdat;

    mcart_btn_deb #(
        .DEB_CYC (DEB_CYC)
    ) u_deb (
        .m2        (m2),
        .map_rst_n (map_rst_n),
        .btn_in    (sys_rst),
        .arm_en    (arm_en),
        .pulse_out (advance)
    );

`ifdef MCART_LOCK_EN
    logic lock_q;
    logic lock_hit;

    assign lock_hit = ~bus.cpu_rw & ((bus.cpu_addr & LOCK_MASK) == LOCK_BASE) & bus.cpu_dat[7];

    always_ff @(negedge m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            lock_q <= 1'b0;
        end else if (lock_hit) begin
            lock_q <= 1'b1;
        end
    end

    assign sel_lock = lock_q;
`else
    logic unused_cpu;

    assign unused_cpu = ^{bus.cpu_addr, bus.cpu_dat, bus.cpu_rw};
    assign sel_lock   = 1'b0;
`endif

    // A save-state load takes priority over a coincident button advance
    always_ff @(negedge m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            game_sel_q <= '0;
        end else if (ss_wr) begin
            game_sel_q <= (ss_val > SEL_MAX) ? '0 : ss_val;
        end else if (advance) begin
            game_sel_q <= (game_sel_q == SEL_MAX) ? '0 : game_sel_q + 1'b1;
        end
    end

    always_comb begin
        rdat = 8'hFF;
        if (bus.ss_addr == SS_ADDR_SEL) begin
            rdat             = 8'h00;
            rdat[SEL_W-1:0]  = game_sel_q;
        end else if (bus.ss_addr == SS_ADDR_IDX) begin
            rdat = bus.map_idx;
        end
    end

    assign bus.ss_rdat = rdat;
    assign game_sel    = game_sel_q;

endmodule

// File: tb/tb_mcart_rst_sel.sv
// Self-checking bench for mcart_rst_sel with GAME_CNT=3, DEB_CYC=4.
// Build with MCART_LOCK_EN defined to exercise the selection lock.
module tb_mcart_rst_sel;
    import mcart_rst_sel_pkg::*;

    localparam int GAME_CNT = 3;
    localparam int SEL_W    = 2;
    localparam int DEB_CYC  = 4;

    logic             m2;
    logic             map_rst_n;
    logic             sys_rst;
    logic [SEL_W-1:0] game_sel;
    logic             sel_lock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int model_sel  = 0;
    int model_lock = 0;

    mcart_rst_sel_if bus ();

    mcart_rst_sel #(
        .GAME_CNT (GAME_CNT),
        .SEL_W    (SEL_W),
        .DEB_CYC  (DEB_CYC)
    ) dut (
        .m2        (m2),
        .map_rst_n (map_rst_n),
        .sys_rst   (sys_rst),
        .bus       (bus.slave),
        .game_sel  (game_sel),
        .sel_lock  (sel_lock)
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge m2);
    endtask

    // Button held for len falling edges, then released for gap edges.
    // A press completes when len reaches DEB_CYC; it counts unless ss_act or the lock masks it.
    task automatic press(input int len, input int gap);
        sys_rst = 1'b1;
        tick(len);
        sys_rst = 1'b0;
        tick(gap);
        if (len >= DEB_CYC && !bus.ss_act && model_lock == 0)
            model_sel = (model_sel + 1) % GAME_CNT;
    endtask

    task automatic ss_write(input logic [7:0] v);
        bus.ss_act  = 1'b1;
        bus.ss_we   = 1'b1;
        bus.ss_addr = SS_ADDR_SEL;
        bus.ss_wdat = v;
        tick(1);
        bus.ss_we  = 1'b0;
        bus.ss_act = 1'b0;
        tick(1);
        model_sel = (int'(v) % (1 << SEL_W) >= GAME_CNT) ? 0 : int'(v) % (1 << SEL_W);
    endtask

    task automatic ss_read(input string tag, input logic [7:0] addr);
        logic [7:0] exp;
        bus.ss_addr = addr;
        #1;
        if (addr == 8'd0)        exp = 8'(model_sel);
        else if (addr == 8'd127) exp = bus.map_idx;
        else                     exp = 8'hFF;
        chk(tag, 16'(bus.ss_rdat), 16'(exp));
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_addr = a;
        bus.cpu_dat  = d;
        bus.cpu_rw   = 1'b0;
        tick(1);
        bus.cpu_rw   = 1'b1;
        tick(1);
`ifdef MCART_LOCK_EN
        if ((a & 16'hF000) == 16'h5000 && d[7]) model_lock = 1;
`endif
    endtask

    initial begin
        map_rst_n    = 1'b0;
        sys_rst      = 1'b0;
        bus.cpu_addr = 16'h0000;
        bus.cpu_dat  = 8'h00;
        bus.cpu_rw   = 1'b1;
        bus.ss_act   = 1'b0;
        bus.ss_we    = 1'b0;
        bus.ss_addr  = 8'h00;
        bus.ss_wdat  = 8'h00;
        bus.map_idx  = 8'h5A;
        #1;
        chk("rst_game_sel", 16'(game_sel), 16'd0);
        chk("rst_sel_lock", 16'(sel_lock), 16'd0);
        chk("rst_fsm_idle", 16'(dut.u_deb.state_q), 16'(IDLE));
        tick(3);
        map_rst_n = 1'b1;
        tick(2);

        // Three clean presses walk 0->1->2->0
        for (int i = 0; i < 3; i++) begin
            press(DEB_CYC + 1, 6);
            chk($sformatf("press_%0d", i), 16'(game_sel), 16'(model_sel));
        end

        press(3, 6);
        chk("glitch_3cyc", 16'(game_sel), 16'(model_sel));
        press(6, 6);
        chk("press_6cyc", 16'(game_sel), 16'(model_sel));
        press(DEB_CYC, 6);
        chk("press_exact", 16'(game_sel), 16'(model_sel));
        press(1000, 6);
        chk("long_hold", 16'(game_sel), 16'(model_sel));

        // Save-state load, out-of-range clamp, and readback
        ss_write(8'h02);
        chk("ss_wr_2", 16'(game_sel), 16'd2);
        ss_read("rd_sel_2", 8'd0);
        ss_write(8'h03);
        chk("ss_wr_3", 16'(game_sel), 16'd0);
        ss_read("rd_sel_0", 8'd0);
        ss_read("rd_idx", 8'd127);
        ss_read("rd_other", 8'd5);

        // Press completed while ss_act is high is lost
        bus.ss_act  = 1'b1;
        bus.ss_addr = 8'd9;
        press(DEB_CYC + 2, 6);
        bus.ss_act  = 1'b0;
        tick(1);
        chk("press_during_ss", 16'(game_sel), 16'(model_sel));

        // Randomised mix of presses, loads and reads
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    bus.ss_act  = ($urandom_range(0, 3) == 0);
                    bus.ss_addr = 8'd1;
                    press($urandom_range(1, 8), $urandom_range(5, 8));
                    bus.ss_act  = 1'b0;
                    tick(1);
                end
                2: ss_write(8'($urandom_range(0, 255)));
                default: begin
                    bus.map_idx = 8'($urandom_range(0, 255));
                    case ($urandom_range(0, 2))
                        0:       ss_read($sformatf("rnd_rd_%0d", i), 8'd0);
                        1:       ss_read($sformatf("rnd_rd_%0d", i), 8'd127);
                        default: ss_read($sformatf("rnd_rd_%0d", i), 8'($urandom_range(1, 126)));
                    endcase
                end
            endcase
            chk($sformatf("rnd_sel_%0d", i), 16'(game_sel), 16'(model_sel));
        end

        // Lock window: 0x7F does not lock, 0x80 does
        cpu_write(16'h5123, 8'h7F);
        chk("lock_7f", 16'(sel_lock), 16'd0);
        cpu_write(16'h6123, 8'h80);
        chk("lock_outside", 16'(sel_lock), 16'd0);
        cpu_write(16'h5123, 8'h80);
        chk("lock_80", 16'(sel_lock), 16'(model_lock));
        press(DEB_CYC + 2, 6);
        chk("press_locked", 16'(game_sel), 16'(model_sel));
        ss_write(8'h01);
        chk("ss_wr_locked", 16'(game_sel), 16'd1);
        chk("lock_kept", 16'(sel_lock), 16'(model_lock));

        // Reset mid-press: state cleared at once, no advance afterwards
        ss_write(8'h02);
        sys_rst = 1'b1;
        tick(4);
        chk("pre_rst_armed", 16'(dut.u_deb.state_q), 16'(ARMED));
        #2;
        map_rst_n = 1'b0;
        #1;
        model_sel  = 0;
        model_lock = 0;
        chk("midrst_sel", 16'(game_sel), 16'd0);
        chk("midrst_fsm", 16'(dut.u_deb.state_q), 16'(IDLE));
        chk("midrst_lock", 16'(sel_lock), 16'd0);
        sys_rst = 1'b0;
        tick(2);
        map_rst_n = 1'b1;
        tick(10);
        chk("post_rst_sel", 16'(game_sel), 16'd0);
        press(DEB_CYC, 6);
        chk("post_rst_press", 16'(game_sel), 16'(model_sel));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
